// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// core's instruction-fetch (I) and data-access (D) ports. One access is in
// flight at a time. D has fixed priority over I because the MEM stage is older
// in program order. Each access produces a single M_EN pulse and a single
// one-cycle DONE pulse on the granted port.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable a starvation guard.
// It forces an I grant after STARVE_LIMIT consecutive D grants made while
// I_REQ was pending. Without the macro, arbitration is strict D-over-I.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,   // legal range 1..15
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  // instruction-fetch port
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_RDATA,
  output logic              I_DONE,
  // data-access port
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_DONE,
  // memory side
  output logic              M_EN,
  output logic              M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA,
  // status
  output logic              ARB_BUSY,
  output logic              GRANT_D
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  localparam logic [3:0] LatInit = 4'(MEM_LATENCY);

  state_e     state_q;
  logic [3:0] lat_cnt_q;
  // Remembers whether the in-flight access is a write, since M_WE is dropped
  // after the issue cycle.
  logic       acc_we_q;

  // High when the starvation guard must hand the next arbitration to I.
  logic       starve_hit;
  // Arbitration outcome in IDLE: grant D this edge.
  logic       grant_d_now;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q;

  assign starve_hit = (starve_cnt_q == 4'(STARVE_LIMIT));

  // Count D grants made while I waits; clear on any I grant or idle I.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt_q <= 4'd0;
    end else if (state_q == StIdle) begin
      if (!I_REQ) begin
        starve_cnt_q <= 4'd0;
      end else if (grant_d_now) begin
        starve_cnt_q <= starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_q <= 4'd0;
      end
    end
  end
`else
  // Guard absent: constant zero, the term only keeps the parameter referenced.
  assign starve_hit = 1'b0 & (STARVE_LIMIT != 0);
`endif

  // D wins unless the guard says I has waited long enough.
  always_comb begin
    grant_d_now = D_REQ && !(I_REQ && starve_hit);
  end

  // Arbitration FSM with registered memory strobes, read data and DONE pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      lat_cnt_q <= 4'd0;
      acc_we_q  <= 1'b0;
      M_EN      <= 1'b0;
      M_WE      <= 1'b0;
      M_ADDR    <= '0;
      M_WDATA   <= '0;
      I_RDATA   <= '0;
      D_RDATA   <= '0;
      I_DONE    <= 1'b0;
      D_DONE    <= 1'b0;
      ARB_BUSY  <= 1'b0;
      GRANT_D   <= 1'b0;
    end else begin
      // DONE is a single-cycle pulse; only the WAIT exit re-raises it.
      I_DONE <= 1'b0;
      D_DONE <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d_now) begin
            M_EN     <= 1'b1;
            M_WE     <= D_WE;
            M_ADDR   <= D_ADDR;
            M_WDATA  <= D_WDATA;
            acc_we_q <= D_WE;
            GRANT_D  <= 1'b1;
            ARB_BUSY <= 1'b1;
            state_q  <= StIssue;
          end else if (I_REQ) begin
            M_EN     <= 1'b1;
            M_WE     <= 1'b0;
            M_ADDR   <= I_ADDR;
            acc_we_q <= 1'b0;
            GRANT_D  <= 1'b0;
            ARB_BUSY <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          M_EN      <= 1'b0;
          M_WE      <= 1'b0;
          lat_cnt_q <= LatInit;
          state_q   <= StWait;
        end
        StWait: begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
          // Count of 1 marks the cycle in which M_RDATA is valid.
          if (lat_cnt_q == 4'd1) begin
            if (GRANT_D) begin
              if (!acc_we_q) begin
                D_RDATA <= M_RDATA;
              end
              D_DONE <= 1'b1;
            end else begin
              I_RDATA <= M_RDATA;
              I_DONE  <= 1'b1;
            end
            ARB_BUSY <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q  <= StIdle;
          ARB_BUSY <= 1'b0;
          M_EN     <= 1'b0;
          M_WE     <= 1'b0;
        end
      endcase
    end
  end

endmodule
